// File: rtl/ex_wb_stage_if.sv
// Bus bundle for ex_wb_stage: instruction issue handshake plus the
// register-file read/write port.
//   master : instruction source + register file (drives in_valid/op/rs*/rd/
//            imm/use_imm and read1/read2)
//   slave  : the stage (drives in_ready, reg1/reg2, write/writereg/data, busy)
interface ex_wb_stage_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic              in_valid;
  logic              in_ready;
  logic [3:0]        op;
  logic [ADDR_W-1:0] rs1;
  logic [ADDR_W-1:0] rs2;
  logic [ADDR_W-1:0] rd;
  logic [DATA_W-1:0] imm;
  logic              use_imm;
  logic [ADDR_W-1:0] reg1;
  logic [ADDR_W-1:0] reg2;
  logic [DATA_W-1:0] read1;
  logic [DATA_W-1:0] read2;
  logic              write;
  logic [ADDR_W-1:0] writereg;
  logic [DATA_W-1:0] data;
  logic              busy;

  modport master (
    output in_valid, op, rs1, rs2, rd, imm, use_imm, read1, read2,
    input  in_ready, reg1, reg2, write, writereg, data, busy
  );

  modport slave (
    input  in_valid, op, rs1, rs2, rd, imm, use_imm, read1, read2,
    output in_ready, reg1, reg2, write, writereg, data, busy
  );
endinterface

// File: rtl/ex_wb_stage.sv
// ex_wb_stage: execute + write-back stage in front of a 32-entry register
// file write port. Reads operands through reg1/reg2, forwards in-flight EX/WB
// results, runs the ALU op and emits a one-cycle write pulse per result.
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous, active-low
//   bus    ex_wb_stage_if.slave (issue handshake, RF read/write, busy)
// Optional feature: define MUL_EN to make op 8 an iterative shift-add MUL
// (DATA_W cycles, busy/in_ready stall). Without it op 8 is an unused code.
module ex_wb_stage #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input logic         clk,
  input logic         reset,
  ex_wb_stage_if.slave bus
);

  typedef struct packed {
    logic              vld;
    logic [3:0]        op;
    logic [ADDR_W-1:0] rd;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
  } ex_t;

  ex_t               ex_q;
  logic [DATA_W-1:0] ex_res;
  logic [DATA_W-1:0] opa;
  logic [DATA_W-1:0] opb;
  logic              op_ok;
  logic              ex_wr;
  logic              accept;
  logic              hold;

`ifdef MUL_EN
  localparam int CNT_W = $clog2(DATA_W);

  typedef enum logic [1:0] {EX_IDLE, EX_MUL, EX_DONE} ex_st_e;
  ex_st_e            st_q, st_d;
  logic [CNT_W-1:0]  cnt_q;
  logic [DATA_W-1:0] acc_q;
  logic [DATA_W-1:0] mcand_q;
  logic [DATA_W-1:0] mplier_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) st_q <= EX_IDLE;
    else        st_q <= st_d;
  end

  always_comb begin
    st_d = st_q;
    case (st_q)
      EX_IDLE: if (accept && bus.op == 4'd8) st_d = EX_MUL;
      EX_MUL:  if (cnt_q == '0) st_d = EX_DONE;
      EX_DONE: st_d = EX_IDLE;
      default: st_d = EX_IDLE;
    endcase
  end

  // One multiplier bit per cycle: multiplicand walks left, multiplier right.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
    end else if (accept && bus.op == 4'd8) begin
      cnt_q    <= CNT_W'(DATA_W - 1);
      acc_q    <= '0;
      mcand_q  <= opa;
      mplier_q <= opb;
    end else if (st_q == EX_MUL) begin
      if (mplier_q[0]) acc_q <= acc_q + mcand_q;
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      cnt_q    <= cnt_q - 1'b1;
    end
  end

  assign bus.busy = (st_q != EX_IDLE);
  // EX contents freeze while iterating; EX_DONE lets them drain to WB.
  assign hold     = (st_q == EX_MUL);
`else
  assign bus.busy = 1'b0;
  assign hold     = 1'b0;
`endif

  assign bus.in_ready = !bus.busy;
  assign accept       = bus.in_valid && bus.in_ready;
  assign bus.reg1     = bus.rs1;
  assign bus.reg2     = bus.rs2;

  // Forwarding: the younger EX result beats the older WB result.
  always_comb begin
    opa = bus.read1;
    if (ex_wr && ex_q.rd == bus.rs1)             opa = ex_res;
    else if (bus.write && bus.writereg == bus.rs1) opa = bus.data;
    opb = bus.read2;
    if (bus.use_imm)                             opb = bus.imm;
    else if (ex_wr && ex_q.rd == bus.rs2)        opb = ex_res;
    else if (bus.write && bus.writereg == bus.rs2) opb = bus.data;
  end

  always_comb begin
    ex_res = '0;
    op_ok  = 1'b1;
    case (ex_q.op)
      4'd0: ex_res = ex_q.a + ex_q.b;
      4'd1: ex_res = ex_q.a - ex_q.b;
      4'd2: ex_res = ex_q.a & ex_q.b;
      4'd3: ex_res = ex_q.a | ex_q.b;
      4'd4: ex_res = ex_q.a ^ ex_q.b;
      4'd5: ex_res = {{(DATA_W-1){1'b0}}, ($signed(ex_q.a) < $signed(ex_q.b))};
      4'd6: ex_res = ex_q.a << ex_q.b[4:0];
      4'd7: ex_res = ex_q.a >> ex_q.b[4:0];
`ifdef MUL_EN
      4'd8: begin
        ex_res = acc_q;
        op_ok  = (st_q == EX_DONE);
      end
`endif
      default: op_ok = 1'b0;
    endcase
  end

  // Only ops that will actually write are forwardable.
  assign ex_wr = ex_q.vld && op_ok;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ex_q <= '0;
    end else if (!hold) begin
      ex_q.vld <= accept;
      if (accept) begin
        ex_q.op <= bus.op;
        ex_q.rd <= bus.rd;
        ex_q.a  <= opa;
        ex_q.b  <= opb;
      end
    end
  end

  // writereg/data hold between results; write is a single-cycle pulse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bus.write    <= 1'b0;
      bus.writereg <= '0;
      bus.data     <= '0;
    end else begin
      bus.write <= ex_wr;
      if (ex_wr) begin
        bus.writereg <= ex_q.rd;
        bus.data     <= ex_res;
      end
    end
  end

endmodule

// File: tb/tb_ex_wb_stage.sv
module tb_ex_wb_stage;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;

  logic clk;
  logic reset;
  int   cyc;
  int   checks;
  int   errors;

  logic [DATA_W-1:0] rf [32];

  typedef struct {
    logic [ADDR_W-1:0] rd;
    logic [DATA_W-1:0] d;
    int                due;
  } exp_t;
  exp_t q[$];
  exp_t mon_e;

  ex_wb_stage_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus();

  ex_wb_stage #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Register file model is read-only: results are never committed, so any
  // dependent op only sees fresh values through forwarding.
  assign bus.read1 = rf[bus.reg1];
  assign bus.read2 = rf[bus.reg2];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h required %h", nm, act, exp);
    end
  endtask

  // Drive one instruction at a negedge; it is accepted at the next posedge.
  task automatic issue(input logic [3:0] op, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [4:0] rd, input logic [31:0] imm, input logic ui,
                       input bit exp_wr, input logic [31:0] exp_d, input int lat);
    exp_t e;
    @(negedge clk);
    chk("in_ready_at_issue", {31'b0, bus.in_ready}, 32'd1);
    bus.in_valid = 1'b1;
    bus.op       = op;
    bus.rs1      = rs1;
    bus.rs2      = rs2;
    bus.rd       = rd;
    bus.imm      = imm;
    bus.use_imm  = ui;
    if (exp_wr) begin
      e.rd  = rd;
      e.d   = exp_d;
      e.due = cyc + lat;
      q.push_back(e);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      bus.in_valid = 1'b0;
    end
  endtask

  // Monitor: every write pulse must match the oldest expectation, including
  // the cycle it lands in.
  initial begin
    forever begin
      @(negedge clk);
      if (bus.write === 1'b1) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL wb_unexpected: got write reg=%0d data=%h cycle=%0d, required no write",
                   bus.writereg, bus.data, cyc);
        end else begin
          mon_e = q.pop_front();
          if (bus.writereg !== mon_e.rd || bus.data !== mon_e.d || cyc != mon_e.due) begin
            errors++;
            $display("FAIL wb_result: got reg=%0d data=%h cycle=%0d, required reg=%0d data=%h cycle=%0d",
                     bus.writereg, bus.data, cyc, mon_e.rd, mon_e.d, mon_e.due);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1);
  end

  initial begin
`ifdef MUL_EN
    int  n;
    bit  bad;
`endif
    checks = 0;
    errors = 0;
    for (int i = 0; i < 32; i++) rf[i] = '0;
    rf[1]  = 32'd10;
    rf[2]  = 32'd20;
    rf[12] = 32'hFFFF_FFFF;
    rf[13] = 32'd1;
    rf[14] = 32'h8000_0000;
    rf[23] = 32'd7;
    bus.in_valid = 1'b0;
    bus.op       = '0;
    bus.rs1      = '0;
    bus.rs2      = '0;
    bus.rd       = '0;
    bus.imm      = '0;
    bus.use_imm  = 1'b0;
    reset        = 1'b1;

    // Reset state
    #3 reset = 1'b0;
    #1;
    chk("rst_write",    {31'b0, bus.write}, 32'd0);
    chk("rst_writereg", {27'b0, bus.writereg}, 32'd0);
    chk("rst_data",     bus.data, 32'd0);
    chk("rst_busy",     {31'b0, bus.busy}, 32'd0);
    chk("rst_in_ready", {31'b0, bus.in_ready}, 32'd1);
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 1'b1;

    // Reset mid-stream: one op in WB, one in EX, both dropped.
    issue(4'd0, 5'd1, 5'd2, 5'd7, 32'd0, 1'b0, 1'b0, 32'd0, 2);
    issue(4'd0, 5'd1, 5'd2, 5'd8, 32'd0, 1'b0, 1'b0, 32'd0, 2);
    @(posedge clk);
    #2;
    chk("pre_rst_write", {31'b0, bus.write}, 32'd1);
    reset = 1'b0;
    bus.in_valid = 1'b0;
    #1;
    chk("async_rst_write",    {31'b0, bus.write}, 32'd0);
    chk("async_rst_data",     bus.data, 32'd0);
    chk("async_rst_in_ready", {31'b0, bus.in_ready}, 32'd1);
    @(negedge clk) reset = 1'b1;
    idle(4);

    // Basic ADD timing
    issue(4'd0, 5'd1, 5'd2, 5'd3, 32'd0, 1'b0, 1'b1, 32'd30, 2);
    idle(3);

    // EX forward
    issue(4'd0, 5'd1, 5'd2, 5'd3, 32'd0, 1'b0, 1'b1, 32'd30, 2);
    issue(4'd1, 5'd3, 5'd1, 5'd4, 32'd0, 1'b0, 1'b1, 32'd20, 2);
    idle(3);

    // WB forward, rs2 ignored under use_imm, EX beats WB
    issue(4'd0, 5'd1, 5'd2, 5'd3, 32'd0,   1'b0, 1'b1, 32'd30, 2);
    issue(4'd0, 5'd0, 5'd0, 5'd5, 32'd5,   1'b1, 1'b1, 32'd5,  2);
    issue(4'd4, 5'd3, 5'd3, 5'd6, 32'hF,   1'b1, 1'b1, 32'd17, 2);
    issue(4'd0, 5'd1, 5'd2, 5'd3, 32'd0,   1'b0, 1'b1, 32'd30, 2);
    issue(4'd0, 5'd1, 5'd0, 5'd3, 32'd1,   1'b1, 1'b1, 32'd11, 2);
    issue(4'd0, 5'd3, 5'd0, 5'd9, 32'd0,   1'b0, 1'b1, 32'd11, 2);
    idle(3);

    // Register 0 is forwarded like any other
    issue(4'd0, 5'd1, 5'd2, 5'd0,  32'd0, 1'b0, 1'b1, 32'd30, 2);
    issue(4'd0, 5'd0, 5'd0, 5'd10, 32'd0, 1'b0, 1'b1, 32'd60, 2);
    idle(3);

    // ALU corners
    issue(4'd1, 5'd0,  5'd0,  5'd11, 32'd1,   1'b1, 1'b1, 32'hFFFF_FFFF, 2);
    issue(4'd5, 5'd12, 5'd13, 5'd15, 32'd0,   1'b0, 1'b1, 32'd1, 2);
    issue(4'd5, 5'd13, 5'd12, 5'd16, 32'd0,   1'b0, 1'b1, 32'd0, 2);
    issue(4'd7, 5'd14, 5'd0,  5'd17, 32'd31,  1'b1, 1'b1, 32'd1, 2);
    issue(4'd7, 5'd14, 5'd0,  5'd18, 32'd33,  1'b1, 1'b1, 32'h4000_0000, 2);
    issue(4'd6, 5'd13, 5'd0,  5'd19, 32'd31,  1'b1, 1'b1, 32'h8000_0000, 2);
    issue(4'd2, 5'd12, 5'd0,  5'd25, 32'hF0,  1'b1, 1'b1, 32'hF0, 2);
    issue(4'd3, 5'd1,  5'd2,  5'd26, 32'd0,   1'b0, 1'b1, 32'd30, 2);
    issue(4'd0, 5'd12, 5'd13, 5'd27, 32'd0,   1'b0, 1'b1, 32'd0, 2);
    // Unused op: no write, and its rd must not be forwarded.
    issue(4'd12, 5'd1, 5'd2,  5'd20, 32'd0,   1'b0, 1'b0, 32'd0, 2);
    issue(4'd0, 5'd20, 5'd13, 5'd21, 32'd0,   1'b0, 1'b1, 32'd1, 2);
    idle(3);

`ifdef MUL_EN
    // MUL 7*6
    issue(4'd8, 5'd23, 5'd0, 5'd22, 32'd6, 1'b1, 1'b1, 32'd42, DATA_W + 2);
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    n   = 0;
    bad = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!bus.busy) break;
      n++;
      if (bus.in_ready) bad = 1'b1;
    end
    chk("mul_busy_cycles", n, DATA_W + 1);
    chk("mul_in_ready_low", {31'b0, bad}, 32'd0);
    idle(3);

    // Reset 10 cycles into a MUL aborts it.
    issue(4'd8, 5'd23, 5'd0, 5'd29, 32'd6, 1'b1, 1'b0, 32'd0, DATA_W + 2);
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    chk("mul_busy_before_rst", {31'b0, bus.busy}, 32'd1);
    reset = 1'b0;
    #1;
    chk("mul_rst_busy",     {31'b0, bus.busy}, 32'd0);
    chk("mul_rst_in_ready", {31'b0, bus.in_ready}, 32'd1);
    @(negedge clk) reset = 1'b1;
    idle(DATA_W + 8);
`else
    // Op 8 without the multiplier: no write, no stall.
    issue(4'd8, 5'd23, 5'd0, 5'd28, 32'd6, 1'b1, 1'b0, 32'd0, 2);
    idle(1);
    chk("op8_busy", {31'b0, bus.busy}, 32'd0);
    idle(3);
`endif

    idle(5);
    chk("drain", q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
